// File: rtl/sigdel_dac_nth.sv
// Selectable 1st/2nd-order CIFB sigma-delta DAC with saturating integrators,
// an OSR-rate sample strobe and a one-deep valid/ready input buffer.
module sigdel_dac_nth #(
  parameter int BITLEN = 16,
  parameter int ORDER  = 2,
  parameter int OSR    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [BITLEN-1:0] in_DAC,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr_flags,
  output logic              out,
  output logic              underrun,
  output logic              sat
);
  localparam int W1 = BITLEN + 2;
  localparam int W2 = BITLEN + 4;
  localparam int SW = BITLEN + 5;
  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [CW-1:0]        CNT_LAST = CW'(OSR - 1);
  localparam logic [BITLEN-1:0]    MID      = {1'b1, {(BITLEN-1){1'b0}}};
  localparam logic signed [SW-1:0] FS       = signed'({{(SW-BITLEN){1'b0}}, MID});
  localparam logic signed [SW-1:0] MAX1     = signed'({{(SW-W1+1){1'b0}}, {(W1-1){1'b1}}});
  localparam logic signed [SW-1:0] MIN1     = -MAX1;
  localparam logic signed [SW-1:0] MAX2     = signed'({{(SW-W2+1){1'b0}}, {(W2-1){1'b1}}});
  localparam logic signed [SW-1:0] MIN2     = -MAX2;

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("sigdel_dac_nth: ORDER must be 1 or 2");
  end
  if (OSR < 2) begin : g_bad_osr
    $error("sigdel_dac_nth: OSR must be at least 2");
  end

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BITLEN-1:0]    buf_q, buf_d;
  logic [BITLEN-1:0]    cur_q, cur_d;
  logic                 bufFull_q, bufFull_d;
  logic signed [W1-1:0] int1_q, int1_d;
  logic signed [W2-1:0] int2_q, int2_d;
  logic                 out_q, out_d;
  logic                 underrun_q, underrun_d;
  logic                 sat_q, sat_d;

  logic                 strobe, transfer;
  logic signed [SW-1:0] xVal, fbVal, int1Ext, int2Ext, sum1, sum2;
  logic signed [W1-1:0] int1Sat;
  logic signed [W2-1:0] int2Sat;
  logic                 clip1, clip2, satSet, undSet;

  assign transfer = in_valid & ~bufFull_q;
  assign strobe   = en & (cnt_q == CNT_LAST);

  // Sums are formed wide enough that no intermediate can wrap before clamping.
  assign xVal    = signed'({{(SW-BITLEN){1'b0}}, cur_q}) - FS;
  assign fbVal   = out_q ? FS : -FS;
  assign int1Ext = signed'({{(SW-W1){int1_q[W1-1]}}, int1_q});
  assign int2Ext = signed'({{(SW-W2){int2_q[W2-1]}}, int2_q});
  assign sum1    = int1Ext + xVal - fbVal;
  assign sum2    = int2Ext + int1Ext - fbVal;

  always_comb begin
    int1Sat = sum1[W1-1:0];
    clip1   = 1'b0;
    if (sum1 > MAX1) begin
      int1Sat = MAX1[W1-1:0];
      clip1   = 1'b1;
    end else if (sum1 < MIN1) begin
      int1Sat = MIN1[W1-1:0];
      clip1   = 1'b1;
    end
    int2Sat = sum2[W2-1:0];
    clip2   = 1'b0;
    if (sum2 > MAX2) begin
      int2Sat = MAX2[W2-1:0];
      clip2   = 1'b1;
    end else if (sum2 < MIN2) begin
      int2Sat = MIN2[W2-1:0];
      clip2   = 1'b1;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    int1_d    = int1_q;
    int2_d    = int2_q;
    out_d     = ~out_q;
    cur_d     = cur_q;
    buf_d     = buf_q;
    bufFull_d = bufFull_q;
    satSet    = 1'b0;
    undSet    = 1'b0;
    if (en) begin
      cnt_d  = strobe ? '0 : cnt_q + CW'(1);
      int1_d = int1Sat;
      if (ORDER == 2) begin
        int2_d = int2Sat;
        satSet = clip1 | clip2;
        out_d  = ~int2_q[W2-1];
      end else begin
        satSet = clip1;
        out_d  = ~int1_q[W1-1];
      end
    end
    // A strobe with an empty buffer may still be served by a same-cycle transfer.
    if (strobe) begin
      if (bufFull_q) begin
        cur_d     = buf_q;
        bufFull_d = 1'b0;
      end else if (transfer) begin
        cur_d = in_DAC;
      end else begin
        undSet = 1'b1;
      end
    end else if (transfer) begin
      buf_d     = in_DAC;
      bufFull_d = 1'b1;
    end
    underrun_d = undSet | (underrun_q & ~clr_flags);
    sat_d      = satSet | (sat_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      cur_q      <= MID;
      bufFull_q  <= 1'b0;
      int1_q     <= '0;
      int2_q     <= '0;
      out_q      <= 1'b0;
      underrun_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      cur_q      <= cur_d;
      bufFull_q  <= bufFull_d;
      int1_q     <= int1_d;
      int2_q     <= int2_d;
      out_q      <= out_d;
      underrun_q <= underrun_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready = ~bufFull_q;
  assign out      = out_q;
  assign underrun = underrun_q;
  assign sat      = sat_q;

endmodule
